// File: rtl/serial_sub_8bit.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock,
// with a valid/ready start handshake and a valid/ready done handshake.
module serial_sub_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high. start_ready is high only in IDLE; done_valid is high only in
    // DONE and drops on the edge that sees done_ready.

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             borrow_nxt;
    logic [WIDTH-1:0] diff_nxt;

    always_comb begin
        d_bit      = a_r[0] ^ b_r[0] ^ borrow;
        borrow_nxt = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & borrow);
        diff_nxt   = {d_bit, diff[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            bout       <= 1'b0;
            ovf        <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    borrow <= borrow_nxt;
                    diff   <= diff_nxt;
                    cnt    <= cnt + 1'b1;
                    // The bit processed on this edge is the MSB, so d_bit is the result sign.
                    if (cnt == LAST_BIT) begin
                        cnt        <= '0;
                        bout       <= borrow_nxt;
                        ovf        <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
                        done_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    done_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign dbg_state   = state;

endmodule
